systolic_gemm: RTL and testbench
================================

// Module: systolic_gemm
// PURPOSE
//  Self-sequencing DIMxDIM output-stationary systolic matrix-multiply engine: C = A(DIMxK) * B(KxDIM).
//  Accepts one A column + one B row per beat (valid/ready), skews inputs internally, flushes the array,
//  then drains C one row per beat (valid/ready). Sits between the operand-fetch DMA and result writeback.
// PARAMETERS
//  BITS_AB  8   signed operand width (A, B elements)
//  BITS_C   16  signed accumulator / result width
//  DIM      8   array dimension (rows = cols), >=2
//  K_W      8   width of k_len; max K = 2**K_W-1
// PORTS
//  clk       in   1              clock, all logic on posedge
//  rst       in   1              synchronous, active-high reset
//  start     in   1              begin job; sampled only in IDLE
//  k_len     in   K_W            beats in this job (inner dimension K), latched on start
//  busy      out  1              high in any state but IDLE
//  in_valid  in   1              operand beat valid
//  in_ready  out  1              engine accepts operand beat
//  in_a      in   DIM x BITS_AB  A column: in_a[r] = A[r][k]
//  in_b      in   DIM x BITS_AB  B row:    in_b[c] = B[k][c]
//  out_valid out  1              result row valid
//  out_ready in   1              downstream accepts result row
//  out_row   out  $clog2(DIM)    index of row on out_c
//  out_c     out  DIM x BITS_C   out_c[c] = C[out_row][c]
//  done      out  1              one-cycle pulse after final row handshake
// BEHAVIOUR
//  - Reset: state=IDLE; all accumulators, skew regs, PE pipes = 0; busy/in_ready/out_valid/done = 0; out_row = 0.
//  - FSM IDLE->FEED->FLUSH->DRAIN->IDLE.
//    IDLE : start=1 -> latch k_len, clear all accumulators, beat_cnt=0; k_len==0 -> DRAIN (all-zero C), else FEED.
//    FEED : in_ready=1. Beat accepted iff in_valid&in_ready; array shifts one step only on accepted beats
//           (stall holds all skew/PE regs). After beat k_len-1 accepted -> FLUSH.
//    FLUSH: in_ready=0; array shifts every cycle injecting zeros; lasts exactly 2*DIM-1 cycles (flush_cnt).
//    DRAIN: out_valid=1, out_c = accumulators of row out_row; out_row advances on out_valid&out_ready;
//           handshake on row DIM-1 -> IDLE, done=1 next cycle, out_row back to 0.
//  - Skew: row r of A delayed r shift-steps, column c of B delayed c shift-steps; A moves right, B moves down,
//    one PE per shift-step. PE(r,c) accumulates A[r][k]*B[k][c] exactly once per k.
//  - Latency (no stalls, out_ready=1): first out_valid K+2*DIM cycles after start accepted; DIM drain cycles.
//  - Arithmetic: product signed 2*BITS_AB, sign-extended/truncated to BITS_C; accumulation wraps mod 2**BITS_C.
//  - start outside IDLE ignored. out_c/out_row stable while out_valid&!out_ready. in_a/in_b ignored when !in_ready.
//  - rst mid-job: immediate return to IDLE with reset values; partial results discarded, no done pulse.
// CONFIGURATION
//  SYSTOLIC_SAT_EN defined: each accumulate saturates to [-2**(BITS_C-1), 2**(BITS_C-1)-1] (sticky at the rail
//    until a signed sum brings it back in range); adds output sat_flag[DIM] (per column, row on out_c hit a rail).
//  Undefined: two's-complement wrap, no sat_flag port.
// STRUCTURE
//  Package systolic_pkg: state_t enum {IDLE,FEED,FLUSH,DRAIN}; default param localparams; function sat_add().
//  Sub-module systolic_pe: one PE (A/B pass-through regs, shift enable, synchronous clear, accumulator,
//    SAT behaviour under the same macro). Top holds FSM, counters, skew registers, row-select mux.
// TESTING
//  1 Identity: DIM=4, A=I, B[k][c]=k*4+c, K=4 -> rows out = B rows; done 1 cycle after row 3 handshake.
//  2 Stall: same job, in_valid toggled 1/0 each cycle and out_ready low 3 cycles on row 1 -> identical C, out_c held.
//  3 Signed/wrap: A=all 127, B=all 127, K=8, BITS_C=16 -> each C = 129032 mod 2**16 = -2040; with SYSTOLIC_SAT_EN -> 32767, sat_flag=all 1.
//  4 k_len=0: start -> no in_ready, straight to DRAIN, 4 rows of zeros, done.
//  5 Reset mid-FLUSH: rst 1 cycle -> IDLE, busy=0, out_valid=0; next job K=2 random -> matches golden model.
//  6 Back-to-back: start asserted during DRAIN ignored; start in IDLE the cycle after done -> accumulators cleared, correct result.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, default parameters and saturating add for the systolic GEMM engine
//
// Purpose : FSM state encoding, default parameter values and the clamp helper
//           used by the processing elements when SYSTOLIC_SAT_EN is defined.
// Contents: state_t, DEF_BITS_AB, DEF_BITS_C, DEF_DIM, DEF_K_W, sat_add().
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } state_t;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_BITS_C  = 16;
  localparam int unsigned DEF_DIM     = 8;
  localparam int unsigned DEF_K_W     = 8;

  // Signed add clamped to a 'bits'-wide signed range (bits <= 31). The sum is
  // formed one bit wider so it never overflows before the clamp is applied.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        bits);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (bits - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) begin
      sat_add = hi[31:0];
    end else if (sum < lo) begin
      sat_add = lo[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one output-stationary multiply-accumulate processing element
//
// Purpose : Registers the A operand (passed right) and B operand (passed down)
//           and accumulates a_in*b_in on every shift step. clr zeroes all state.
// Ports   : clk, rst (sync, active-high), shift_en, clr,
//           a_in/b_in (operands from left/top), a_out/b_out (to right/bottom),
//           acc (accumulator), sat (sticky clamp flag, SYSTOLIC_SAT_EN only).
// Config  : SYSTOLIC_SAT_EN selects saturating accumulation; otherwise wrap.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic                      clr,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  output logic signed [BITS_AB-1:0] a_out,
  output logic signed [BITS_AB-1:0] b_out,
  output logic signed [BITS_C-1:0]  acc
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                      sat
`endif
);

  logic signed [BITS_AB-1:0]   a_q, a_d;
  logic signed [BITS_AB-1:0]   b_q, b_d;
  logic signed [BITS_C-1:0]    acc_q, acc_d;
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    prod_c;

  assign prod   = a_in * b_in;
  // Sized cast of a signed value: sign-extends or truncates to accumulator width.
  assign prod_c = BITS_C'(prod);

`ifdef SYSTOLIC_SAT_EN
  logic               sat_q, sat_d;
  logic signed [31:0] sum_exact;
  logic signed [31:0] sum_sat;

  assign sum_exact = 32'(acc_q) + 32'(prod_c);
  assign sum_sat   = sat_add(32'(acc_q), 32'(prod_c), BITS_C);
  assign sat       = sat_q;
`endif

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
`ifdef SYSTOLIC_SAT_EN
    sat_d = sat_q;
`endif
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
`ifdef SYSTOLIC_SAT_EN
      sat_d = 1'b0;
`endif
    end else if (shift_en) begin
      a_d = a_in;
      b_d = b_in;
`ifdef SYSTOLIC_SAT_EN
      acc_d = BITS_C'(sum_sat);
      if (sum_sat != sum_exact) begin
        sat_d = 1'b1;
      end
`else
      acc_d = acc_q + prod_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
`ifdef SYSTOLIC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
`ifdef SYSTOLIC_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_gemm.sv
// rtl/systolic_gemm.sv - self-sequencing DIMxDIM output-stationary systolic GEMM engine
//
// Purpose : C = A(DIMxK) * B(KxDIM). Takes one A column + one B row per beat,
//           skews them into the PE grid, flushes, then drains one C row per beat.
// Ports   : clk, rst (sync, active-high), start, k_len, busy,
//           in_valid/in_ready/in_a/in_b (operand stream),
//           out_valid/out_ready/out_row/out_c (result stream), done (pulse),
//           sat_flag (per column rail hit, SYSTOLIC_SAT_EN only).
// Config  : SYSTOLIC_SAT_EN enables saturating accumulation and sat_flag.
module systolic_gemm
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM,
  parameter int K_W     = DEF_K_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [K_W-1:0]                 k_len,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0]    in_a,
  input  logic [DIM-1:0][BITS_AB-1:0]    in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DIM)-1:0]         out_row,
  output logic [DIM-1:0][BITS_C-1:0]     out_c,
  output logic                           done
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic [DIM-1:0]                 sat_flag
`endif
);

  localparam int RW = $clog2(DIM);
  localparam int FW = $clog2(2 * DIM);
  // The last PE sees its final operand 2*DIM-2 steps after the last beat; the
  // flush runs one step longer so the drain never races the final accumulate.
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * DIM - 2);

  state_t         state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d;
  logic [K_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]  out_row_q, out_row_d;
  logic           busy_q, busy_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           done_q, done_d;

  logic in_fire;
  logic out_fire;
  logic shift_en;
  logic clr;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;
  assign shift_en = in_fire | (state_q == FLUSH);
  assign clr      = (state_q == IDLE) & start;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    out_row_d   = out_row_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d    = k_len;
          beat_cnt_d = '0;
          state_d    = (k_len == '0) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (in_fire) begin
          if (beat_cnt_q == k_len_q - K_W'(1)) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + K_W'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = DRAIN;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_row_q == RW'(DIM - 1)) begin
            state_d   = IDLE;
            out_row_d = '0;
            done_d    = 1'b1;
          end else begin
            out_row_d = out_row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == FEED);
    out_valid_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_row_q   <= out_row_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign done      = done_q;

  // Zeros are injected during FLUSH; in FEED the array only moves on accepted beats.
  logic [DIM-1:0][BITS_AB-1:0] a_feed, b_feed;
  logic [DIM-1:0][BITS_AB-1:0] a_skew, b_skew;

  assign a_feed = (state_q == FEED) ? in_a : '0;
  assign b_feed = (state_q == FEED) ? in_b : '0;

  // Lane r of A and lane c of B are delayed by their index in shift steps.
  for (genvar r = 0; r < DIM; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign a_skew[r] = a_feed[r];
      assign b_skew[r] = b_feed[r];
    end else begin : g_chain
      logic [r-1:0][BITS_AB-1:0] sa_q, sa_d;
      logic [r-1:0][BITS_AB-1:0] sb_q, sb_d;
      always_comb begin
        sa_d = sa_q;
        sb_d = sb_q;
        if (clr) begin
          sa_d = '0;
          sb_d = '0;
        end else if (shift_en) begin
          sa_d[0] = a_feed[r];
          sb_d[0] = b_feed[r];
          for (int j = 1; j < r; j++) begin
            sa_d[j] = sa_q[j-1];
            sb_d[j] = sb_q[j-1];
          end
        end
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          sa_q <= '0;
          sb_q <= '0;
        end else begin
          sa_q <= sa_d;
          sb_q <= sb_d;
        end
      end
      assign a_skew[r] = sa_q[r-1];
      assign b_skew[r] = sb_q[r-1];
    end
  end

  logic [BITS_AB-1:0] a_h [DIM][DIM];
  logic [BITS_AB-1:0] b_v [DIM][DIM];
  logic [BITS_C-1:0]  acc_w [DIM][DIM];
  // Pass-through outputs of the right column / bottom row leave the array here.
  logic [BITS_AB-1:0] unused_a [DIM];
  logic [BITS_AB-1:0] unused_b [DIM];
`ifdef SYSTOLIC_SAT_EN
  logic               sat_w [DIM][DIM];
`endif

  for (genvar r = 0; r < DIM; r++) begin : g_row
    assign a_h[r][0] = a_skew[r];
    assign b_v[0][r] = b_skew[r];
    for (genvar c = 0; c < DIM; c++) begin : g_pe
      logic [BITS_AB-1:0] a_o, b_o;
      systolic_pe #(
        .BITS_AB(BITS_AB),
        .BITS_C (BITS_C)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .shift_en(shift_en),
        .clr     (clr),
        .a_in    (a_h[r][c]),
        .b_in    (b_v[r][c]),
        .a_out   (a_o),
        .b_out   (b_o),
        .acc     (acc_w[r][c])
`ifdef SYSTOLIC_SAT_EN
        ,
        .sat     (sat_w[r][c])
`endif
      );
      if (c < DIM - 1) begin : g_a_next
        assign a_h[r][c+1] = a_o;
      end else begin : g_a_edge
        assign unused_a[r] = a_o;
      end
      if (r < DIM - 1) begin : g_b_next
        assign b_v[r+1][c] = b_o;
      end else begin : g_b_edge
        assign unused_b[c] = b_o;
      end
    end
  end

  always_comb begin
    out_c = '0;
    for (int c = 0; c < DIM; c++) begin
      out_c[c] = acc_w[out_row_q][c];
    end
  end

`ifdef SYSTOLIC_SAT_EN
  always_comb begin
    sat_flag = '0;
    for (int c = 0; c < DIM; c++) begin
      sat_flag[c] = sat_w[out_row_q][c];
    end
  end
`endif

endmodule

// File: tb/tb_systolic_gemm.sv
// tb/tb_systolic_gemm.sv - self-checking bench for systolic_gemm against a plain matrix-product model
module tb_systolic_gemm;

  localparam int DIM = 4;
  localparam int BAB = 8;
  localparam int BC  = 16;
  localparam int KW  = 8;
`ifdef SYSTOLIC_SAT_EN
  localparam logic [BC-1:0] EXP_127 = 16'h7FFF;
`else
  localparam logic [BC-1:0] EXP_127 = 16'hF808;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [KW-1:0]             k_len = '0;
  logic                      busy;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [DIM-1:0][BAB-1:0]   in_a = '0;
  logic [DIM-1:0][BAB-1:0]   in_b = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic [1:0]                out_row;
  logic [DIM-1:0][BC-1:0]    out_c;
  logic                      done;
`ifdef SYSTOLIC_SAT_EN
  logic [DIM-1:0]            sat_flag;
  logic [DIM-1:0]            got_sat [DIM];
`endif

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int t_start = 0;
  int first_t = 0;
  bit order_ok;
  bit done_ok;
  logic signed [7:0] ma [DIM][256];
  logic signed [7:0] mb [256][DIM];
  logic [BC-1:0]     got [DIM][DIM];

  systolic_gemm #(
    .BITS_AB(BAB),
    .BITS_C (BC),
    .DIM    (DIM),
    .K_W    (KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_c    (out_c),
    .done     (done)
`ifdef SYSTOLIC_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog ncyc %0d limit reached", ncyc);
    $fatal(1, "watchdog expired");
  end

  // C[r][c] = sum_k A[r][k]*B[k][c], reduced to BC bits (clamped per step when saturating).
  function automatic logic [BC-1:0] ref_c(input int r, input int c, input int k);
    int acc;
    acc = 0;
    for (int kk = 0; kk < k; kk++) begin
      acc = acc + int'(ma[r][kk]) * int'(mb[kk][c]);
`ifdef SYSTOLIC_SAT_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
`endif
    end
    return BC'(acc);
  endfunction

  task automatic fill(input int k, input int kind);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < DIM; i++) begin
        case (kind)
          0: begin
            ma[i][kk] = 8'($urandom);
            mb[kk][i] = 8'($urandom);
          end
          1: begin
            ma[i][kk] = (i == kk) ? 8'sd1 : 8'sd0;
            mb[kk][i] = 8'(kk * 4 + i);
          end
          default: begin
            ma[i][kk] = 8'sd127;
            mb[kk][i] = 8'sd127;
          end
        endcase
      end
    end
  endtask

  task automatic start_job(input int k);
    start   = 1'b1;
    k_len   = KW'(k);
    t_start = ncyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int k, input bit toggle);
    int beat;
    int cyc;
    bit v;
    bit fire;
    beat = 0;
    cyc  = 0;
    v    = 1'b1;
    while (beat < k && cyc < 4000) begin
      in_valid = toggle ? v : 1'b1;
      if (in_valid) begin
        for (int i = 0; i < DIM; i++) begin
          in_a[i] = ma[i][beat];
          in_b[i] = mb[beat][i];
        end
      end else begin
        in_a = 32'($urandom);
        in_b = 32'($urandom);
      end
      fire = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      v = !v;
      if (fire) beat++;
    end
    in_valid = 1'b0;
    in_a = 32'($urandom);
    in_b = 32'($urandom);
    checks++;
    if (beat < k) begin
      errors++;
      $display("FAIL feed_timeout beats %0d required %0d", beat, k);
    end
  endtask

  task automatic collect(input bit start_during);
    int row;
    int cyc;
    row       = 0;
    cyc       = 0;
    out_ready = 1'b1;
    order_ok  = 1'b1;
    first_t   = -1;
    while (row < DIM && cyc < 1000) begin
      if (out_valid) begin
        if (row == 0) first_t = ncyc;
        if (out_row !== 2'(row)) order_ok = 1'b0;
        for (int c = 0; c < DIM; c++) got[row][c] = out_c[c];
`ifdef SYSTOLIC_SAT_EN
        got_sat[row] = sat_flag;
`endif
        row++;
      end
      start = start_during && out_valid;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (row < DIM) begin
      errors++;
      $display("FAIL drain_timeout rows %0d required %0d", row, DIM);
    end
    done_ok = done && !busy && !out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl got %b required 0000", {busy, in_ready, out_valid, done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_row !== 2'd0 || out_c !== '0) begin
      errors++;
      $display("FAIL reset_data row %0d c %h required 0/0", out_row, out_c);
    end
  endtask

  task automatic test_identity();
    fill(4, 1);
    start_job(4);
    feed(4, 1'b0);
    collect(1'b0);
    checks++;
    if (first_t - t_start !== 4 + 2 * DIM) begin
      errors++;
      $display("FAIL ident_latency got %0d required %0d", first_t - t_start, 4 + 2 * DIM);
    end
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (got[r][c] !== BC'(r * 4 + c)) begin
          errors++;
          $display("FAIL ident_c[%0d][%0d] got %0d required %0d", r, c, got[r][c], r * 4 + c);
        end
      end
    end
    checks++;
    if (!order_ok || !done_ok) begin
      errors++;
      $display("FAIL ident_order_done order %0d done %0d required 1 1", order_ok, done_ok);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL ident_done_pulse got %b required 0", done);
    end
  endtask

  task automatic test_stall();
    int row;
    int cyc;
    int hold;
    bit held_ok;
    logic [DIM-1:0][BC-1:0] held;
    fill(4, 1);
    start_job(4);
    feed(4, 1'b1);
    row     = 0;
    cyc     = 0;
    hold    = 0;
    held_ok = 1'b1;
    held    = '0;
    while (row < DIM && cyc < 1000) begin
      out_ready = 1'b1;
      if (out_valid) begin
        if (row == 1 && hold < 3) begin
          out_ready = 1'b0;
          if (hold == 0) held = out_c;
          else if (out_c !== held || out_row !== 2'd1) held_ok = 1'b0;
          hold++;
        end else begin
          if (row == 1 && out_c !== held) held_ok = 1'b0;
          for (int c = 0; c < DIM; c++) got[row][c] = out_c[c];
          row++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (row < DIM || !held_ok) begin
      errors++;
      $display("FAIL stall_hold rows %0d held_ok %0d required %0d 1", row, held_ok, DIM);
    end
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (got[r][c] !== BC'(r * 4 + c)) begin
          errors++;
          $display("FAIL stall_c[%0d][%0d] got %0d required %0d", r, c, got[r][c], r * 4 + c);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got %b required 1", done);
    end
  endtask

  task automatic test_wrap();
    fill(8, 2);
    start_job(8);
    feed(8, 1'b0);
    collect(1'b0);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (got[r][c] !== EXP_127) begin
          errors++;
          $display("FAIL wrap_c[%0d][%0d] got %h required %h", r, c, got[r][c], EXP_127);
        end
      end
`ifdef SYSTOLIC_SAT_EN
      checks++;
      if (got_sat[r] !== 4'hF) begin
        errors++;
        $display("FAIL sat_flag[%0d] got %b required 1111", r, got_sat[r]);
      end
`endif
    end
  endtask

  task automatic test_k0();
    start_job(0);
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b101) begin
      errors++;
      $display("FAIL k0_state got %b required 101", {busy, in_ready, out_valid});
    end
    collect(1'b0);
    for (int r = 0; r < DIM; r++) begin
      checks++;
      if ({got[r][0], got[r][1], got[r][2], got[r][3]} !== 64'd0) begin
        errors++;
        $display("FAIL k0_row[%0d] got %h %h %h %h required 0", r, got[r][0], got[r][1], got[r][2], got[r][3]);
      end
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL k0_done got %0d required 1", done_ok);
    end
  endtask

  task automatic test_reset_flush();
    bit seen;
    fill(3, 0);
    start_job(3);
    feed(3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_state got %b required 10", {busy, out_valid});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid, done} !== 4'b0000 || out_row !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid got %b row %0d required 0000 0", {busy, in_ready, out_valid, done}, out_row);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || out_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_quiet got activity 1 required 0");
    end
    fill(2, 0);
    start_job(2);
    feed(2, 1'b0);
    collect(1'b0);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (got[r][c] !== ref_c(r, c, 2)) begin
          errors++;
          $display("FAIL rst_job_c[%0d][%0d] got %h required %h", r, c, got[r][c], ref_c(r, c, 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill(5, 0);
    start_job(5);
    feed(5, 1'b0);
    k_len = '0;
    collect(1'b1);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (got[r][c] !== ref_c(r, c, 5)) begin
          errors++;
          $display("FAIL b2b_first_c[%0d][%0d] got %h required %h", r, c, got[r][c], ref_c(r, c, 5));
        end
      end
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL b2b_done got %0d required 1", done_ok);
    end
    fill(3, 0);
    start_job(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart busy %b required 1", busy);
    end
    feed(3, 1'b0);
    collect(1'b0);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (got[r][c] !== ref_c(r, c, 3)) begin
          errors++;
          $display("FAIL b2b_second_c[%0d][%0d] got %h required %h", r, c, got[r][c], ref_c(r, c, 3));
        end
      end
    end
  endtask

  task automatic test_random();
    int k;
    for (int j = 0; j < 4; j++) begin
      k = $urandom_range(1, 12);
      fill(k, 0);
      start_job(k);
      feed(k, 1'($urandom));
      collect(1'b0);
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          checks++;
          if (got[r][c] !== ref_c(r, c, k)) begin
            errors++;
            $display("FAIL rand%0d_c[%0d][%0d] k %0d got %h required %h", j, r, c, k, got[r][c], ref_c(r, c, k));
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_identity();
    test_stall();
    @(negedge clk);
    test_wrap();
    test_k0();
    test_reset_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
